// File: rtl/iterative_divider_if.sv
// Shared operation/flag types and the execute-stage divide handshake bundle.
// The ALU owns the full opcode and flag layouts; the divider only interprets DIV/MOD and Z/N/V.
package iterative_divider_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBB = 4'd3,
    CMP = 4'd4, DIV = 4'd5, MOD = 4'd6, NOP = 4'd7
  } eOperation;

  typedef struct packed {
    logic [3:0] Other;
    logic       Carry;
    logic       Overflow;
    logic       Negative;
    logic       Zero;
  } sFlags;
endpackage

interface iterative_divider_if #(parameter int DataWidth = 16);
  import iterative_divider_pkg::*;

  logic                 Start;
  eOperation            Operation;
  logic [DataWidth-1:0] InDest;
  logic [DataWidth-1:0] InSrc;
  sFlags                InFlags;
  logic                 Busy;
  logic                 Done;
  logic [DataWidth-1:0] OutDest;
  sFlags                OutFlags;

  modport master (output Start, Operation, InDest, InSrc, InFlags,
                  input  Busy, Done, OutDest, OutFlags);
  modport slave  (input  Start, Operation, InDest, InSrc, InFlags,
                  output Busy, Done, OutDest, OutFlags);
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle signed DIV/MOD unit: restoring divide on magnitudes, one quotient bit per clock,
// then sign fix-up. Fixed latency of DataWidth+2 cycles from accept to the Done cycle.
module iterative_divider #(
  parameter int DataWidth = 16
) (
  input logic                 Clock,
  input logic                 nReset,
  iterative_divider_if.slave  bus
);
  import iterative_divider_pkg::*;

  localparam int W  = DataWidth;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    quo, rem, dsr;
  logic            op_div, neg_q, neg_r, dsr_zero, mn_neg1;
  sFlags           flags_l;
  logic [W-1:0]    out_dest;
  sFlags           out_flags;

  // Magnitudes are unsigned W-bit values, so 2^(W-1) from the most negative input is exact.
  logic [W-1:0]    dvd_abs, dsr_abs;
  logic [W:0]      shifted;
  logic [W-1:0]    diff;
  logic            ge;
  logic [W-1:0]    q_fix, r_fix, res;
  sFlags           res_flags;

  always_comb begin
    dvd_abs = bus.InDest[W-1] ? (~bus.InDest + 1'b1) : bus.InDest;
    dsr_abs = bus.InSrc[W-1]  ? (~bus.InSrc  + 1'b1) : bus.InSrc;
  end

  // Restoring step: partial remainder stays below |divisor| <= 2^(W-1), so diff fits W bits.
  always_comb begin
    shifted = {rem, quo[W-1]};
    ge      = (shifted >= {1'b0, dsr});
    diff    = shifted[W-1:0] - dsr;
  end

  always_comb begin
    q_fix = neg_q ? (~quo + 1'b1) : quo;
    r_fix = neg_r ? (~rem + 1'b1) : rem;
    res   = op_div ? (dsr_zero ? '1 : q_fix) : r_fix;
    res_flags          = flags_l;
    res_flags.Zero     = (res == '0);
    res_flags.Negative = res[W-1];
    res_flags.Overflow = dsr_zero | (op_div & mn_neg1);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.Start && (bus.Operation == DIV || bus.Operation == MOD)) begin
              accept    = 1'b1;
              state_nxt = CALC;
            end
      CALC: if (cnt == CW'(W-1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state     <= IDLE;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dsr       <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dsr_zero  <= 1'b0;
      mn_neg1   <= 1'b0;
      flags_l   <= '0;
      out_dest  <= '0;
      out_flags <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
                cnt      <= '0;
                quo      <= dvd_abs;
                rem      <= '0;
                dsr      <= dsr_abs;
                op_div   <= (bus.Operation == DIV);
                neg_q    <= bus.InDest[W-1] ^ bus.InSrc[W-1];
                neg_r    <= bus.InDest[W-1];
                dsr_zero <= (bus.InSrc == '0);
                mn_neg1  <= (bus.InDest == {1'b1, {(W-1){1'b0}}}) && (bus.InSrc == '1);
                flags_l  <= bus.InFlags;
              end
        CALC: begin
                cnt <= cnt + 1'b1;
                rem <= ge ? diff : shifted[W-1:0];
                quo <= {quo[W-2:0], ge};
              end
        FIX:  begin
                out_dest  <= res;
                out_flags <= res_flags;
              end
        default: ;
      endcase
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = (state == DONE);
  assign bus.OutDest  = out_dest;
  assign bus.OutFlags = out_flags;

endmodule
